actbuf_fill_arb: RTL and testbench
==================================

Name: actbuf_fill_arb

Overview:
- Round-robin arbiter sharing one activation-buffer fill stream between N_REQ super-block controllers.
- Each controller raises its activation-buffer write request; the arbiter grants exactly one at a time.
- It opens the loader stream for a fixed-length burst and steers the loader's beat-valid back to the granted controller as its activation-buffer write-valid.
- Sits between the sblk controllers and the off-chip activation loader.

Parameters:
N_REQ, 4, number of requesting super-block controllers (>=2)
BURST_LEN, 27, beats per granted fill burst (>=1)
CNT_W, $clog2(BURST_LEN+1), beat counter width (derived, not overridden)

Ports:
clk_l  input  1  core clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-controller fill request (level, from each actbuf_wr_req)
wr_vld  output  N_REQ  per-controller write-valid (one-hot or zero, to each actbuf_wr_vld)
src_rdy  output  1  arbiter ready to accept a loader beat
src_vld  input  1  loader beat valid
grant_id  output  $clog2(N_REQ)  index of current grantee
grant_vld  output  1  a grant is active
burst_done  output  1  one-cycle pulse after last beat of a burst
ovf_err  output  1  sticky: loader drove src_vld while src_rdy=0

Behaviour:
- Reset values:
  - wr_vld=0, src_rdy=0, grant_id=0, grant_vld=0, burst_done=0, ovf_err=0.
  - Internal: beat_cnt=0, last_grant=N_REQ-1, so index 0 wins first; state=IDLE.
- Reset asserted mid-burst aborts immediately: all of the above reset values, partial beats discarded, no burst_done.
- States:
  - IDLE: src_rdy=0, grant_vld=0.
    - If any req bit is set, pick the first set bit scanning last_grant+1, last_grant+2, ... modulo N_REQ.
    - Register it into grant_id, set grant_vld, clear beat_cnt, go XFER.
    - Latency: req high at edge t gives grant_vld=1 and src_rdy=1 after edge t+1's update (one cycle).
  - XFER: src_rdy=1, grant_vld=1.
    - Beat = src_vld & src_rdy.
    - wr_vld[grant_id] = beat, combinational same cycle; all other wr_vld bits are 0.
    - Each beat increments beat_cnt.
    - On the beat where beat_cnt==BURST_LEN-1: go DONE, and last_grant<=grant_id.
    - Cycles without src_vld simply stall; there is no timeout.
  - DONE: burst_done=1 for exactly this cycle, src_rdy=0, wr_vld=0, grant_vld=0. Unconditionally go IDLE next.
- Minimum gap between bursts: the DONE and IDLE cycles, i.e. 2 cycles from the last beat to the next src_rdy.
- Request changes:
  - Grantee deasserting req during XFER is ignored; the burst always completes BURST_LEN beats.
  - New or changed req bits during XFER/DONE are sampled only in IDLE.
- Fairness: a grantee with req still high after DONE is lowest priority next arbitration. With all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0,...
- BURST_LEN=1: a single beat moves XFER to DONE.
- ovf_err: set on any cycle with src_vld=1 and src_rdy=0. Cleared only by reset. The beat is dropped (no wr_vld).
- beat_cnt never exceeds BURST_LEN-1. No wrap within a burst.

Test Plan:
- Reset then req=4'b0100 at cycle 10, src_vld held 1 → grant_id=2, grant_vld=1 at cycle 11; wr_vld=4'b0100 for exactly 27 cycles; burst_done pulses one cycle later; src_rdy low for 2 cycles.
- req=4'b1111 held, src_vld=1 → grant order 0,1,2,3,0; each burst 27 wr_vld pulses; wr_vld never has more than one bit set.
- Single requester req=4'b0001, src_vld toggled 1,0,1,0 → burst spans 53 cycles; beat count on wr_vld[0]=27; burst_done only after the 27th beat.
- Grantee drops req after 10 beats; req[3] rises mid-burst → burst finishes 27 beats for the original grantee; next grant_id=3.
- src_vld=1 in IDLE and in the DONE cycle → ovf_err=1 and stays 1; no wr_vld pulse for those cycles.
- rst_n pulled low after 12 beats of a burst → all outputs 0 asynchronously, no burst_done. After release, req=4'b0010 gives grant_id=1 with a full 27-beat burst.

Source files
------------

// File: rtl/actbuf_fill_arb.sv
// actbuf_fill_arb
//   Round-robin arbiter that shares one off-chip activation-loader stream
//   between N_REQ super-block controllers. A winning controller receives one
//   fixed-length burst of BURST_LEN beats. Each loader beat is forwarded as
//   that controller's activation-buffer write-valid.
//
// Ports
//   clk_l       core clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         per-controller fill request (level)
//   wr_vld      per-controller write-valid, one-hot or zero
//   src_rdy     arbiter accepts a loader beat this cycle
//   src_vld     loader beat valid
//   grant_id    index of the current grantee
//   grant_vld   a grant (burst) is active
//   burst_done  one-cycle pulse following the last beat of a burst
//   ovf_err     sticky: loader drove src_vld while src_rdy was low
module actbuf_fill_arb #(
  parameter  int N_REQ     = 4,
  parameter  int BURST_LEN = 27,
  localparam int CNT_W     = $clog2(BURST_LEN + 1),
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] wr_vld,
  output logic             src_rdy,
  input  logic             src_vld,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld,
  output logic             burst_done,
  output logic             ovf_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              ovf_err_q, ovf_err_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic              beat;

  // Round-robin pick: scan offsets N_REQ down to 1 from last_grant so that
  // the smallest offset (the nearest requester after last_grant) is written
  // last and wins. Offset N_REQ is last_grant itself, which is therefore the
  // lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      int idx;
      idx = int'(last_grant_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  assign src_rdy    = (state_q == ST_XFER);
  assign grant_vld  = (state_q == ST_XFER);
  assign burst_done = (state_q == ST_DONE);
  assign grant_id   = grant_id_q;
  assign ovf_err    = ovf_err_q;
  assign beat       = src_vld & src_rdy;

  // A beat is steered combinationally to the grantee only.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wr_vld
      assign wr_vld[gi] = beat && (grant_id_q == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    // A beat offered while not ready is dropped; flag it until reset.
    ovf_err_d    = ovf_err_q | (src_vld & ~src_rdy);

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat) begin
          if (beat_cnt_q == LAST_BEAT) begin
            // Counter stays at the last beat; it is cleared on the next grant.
            state_d      = ST_DONE;
            last_grant_d = grant_id_q;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_ID;
      beat_cnt_q   <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

endmodule

// File: tb/tb_actbuf_fill_arb.sv
// tb_actbuf_fill_arb
//   Directed scenarios followed by a randomized run. A burst-level reference
//   model predicts the expected outputs on every cycle.
module tb_actbuf_fill_arb;
  localparam int N  = 4;
  localparam int BL = 27;
  localparam int IW = $clog2(N);

  logic          clk_l = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          src_vld = 1'b0;
  logic [N-1:0]  wr_vld;
  logic          src_rdy;
  logic [IW-1:0] grant_id;
  logic          grant_vld;
  logic          burst_done;
  logic          ovf_err;

  actbuf_fill_arb #(.N_REQ(N), .BURST_LEN(BL)) dut (
    .clk_l      (clk_l),
    .rst_n      (rst_n),
    .req        (req),
    .wr_vld     (wr_vld),
    .src_rdy    (src_rdy),
    .src_vld    (src_vld),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld),
    .burst_done (burst_done),
    .ovf_err    (ovf_err)
  );

  always #5 clk_l = ~clk_l;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=idle, 1=transferring, 2=done pulse.
  int m_phase, m_gid, m_last, m_beats;
  bit m_ovf;

  // Logs of what the DUT actually did, for the directed checks.
  int grant_log[$];
  int burst_log[$];
  int beat_acc;
  bit prev_gv;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_gid = 0; m_last = N - 1; m_beats = 0; m_ovf = 0;
    grant_log.delete(); burst_log.delete(); beat_acc = 0; prev_gv = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic v);
    if (v && m_phase != 1) m_ovf = 1;
    case (m_phase)
      0: if (r != 0) begin
           bit found = 0;
           for (int k = 1; k <= N; k++) begin
             int c = (m_last + k) % N;
             if (!found && r[c]) begin m_gid = c; found = 1; end
           end
           m_beats = 0;
           m_phase = 1;
         end
      1: if (v) begin
           m_beats++;
           if (m_beats == BL) begin m_phase = 2; m_last = m_gid; end
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_outputs();
    int exp_wr;
    exp_wr = (m_phase == 1 && src_vld) ? (1 << m_gid) : 0;
    check("src_rdy",    int'(src_rdy),    int'(m_phase == 1));
    check("grant_vld",  int'(grant_vld),  int'(m_phase == 1));
    check("burst_done", int'(burst_done), int'(m_phase == 2));
    check("ovf_err",    int'(ovf_err),    int'(m_ovf));
    check("wr_vld",     int'(wr_vld),     exp_wr);
    check("wr_onehot",  int'($countones(wr_vld) > 1), 0);
    if (m_phase == 1) check("grant_id", int'(grant_id), m_gid);
  endtask

  task automatic observe();
    if (grant_vld && !prev_gv) grant_log.push_back(int'(grant_id));
    prev_gv = grant_vld;
    beat_acc += $countones(wr_vld);
    if (burst_done) begin
      burst_log.push_back(beat_acc);
      $display("burst grant=%0d beats=%0d t=%0t", m_gid, beat_acc, $time);
      beat_acc = 0;
    end
  endtask

  // One clock cycle: drive after the falling edge, check, then advance model.
  task automatic cyc(input logic [N-1:0] r, input logic v);
    @(negedge clk_l);
    req = r;
    src_vld = v;
    #1;
    compare_outputs();
    observe();
    @(posedge clk_l);
    model_step(r, v);
  endtask

  // Reset asserted between edges; outputs must drop without a clock edge.
  task automatic do_reset(input int hold);
    @(negedge clk_l);
    req = '0;
    src_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_vld",     int'(wr_vld),     0);
    check("rst_src_rdy",    int'(src_rdy),    0);
    check("rst_grant_id",   int'(grant_id),   0);
    check("rst_grant_vld",  int'(grant_vld),  0);
    check("rst_burst_done", int'(burst_done), 0);
    check("rst_ovf_err",    int'(ovf_err),    0);
    model_reset();
    repeat (hold) @(negedge clk_l);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset(3);

    // 1: single requester 2, src_vld held high (also sets ovf in idle)
    repeat (9) cyc(4'b0000, 1'b1);
    repeat (32) cyc(4'b0100, 1'b1);
    check("t1_ngrants", int'(grant_log.size() >= 2), 1);
    check("t1_nbursts", int'(burst_log.size() >= 1), 1);
    if (grant_log.size() >= 2) begin
      check("t1_grant0", grant_log[0], 2);
      check("t1_grant1", grant_log[1], 2);
    end
    if (burst_log.size() >= 1) check("t1_beats", burst_log[0], BL);

    // 2: all requesting, rotation 0,1,2,3,0
    do_reset(2);
    repeat (5 * (BL + 2) + 2) cyc(4'b1111, 1'b1);
    check("t2_ngrants", int'(grant_log.size() >= 5), 1);
    check("t2_nbursts", int'(burst_log.size() >= 5), 1);
    if (grant_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("t2_grant%0d", i), grant_log[i], i % N);
    end
    if (burst_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("t2_beats%0d", i), burst_log[i], BL);
    end

    // 3: single requester, src_vld toggling; burst spans 53 cycles
    do_reset(2);
    begin
      int span = 0;
      bit in_burst = 0;
      for (int i = 0; i < 70; i++) begin
        cyc(4'b0001, (i % 2) == 1);
        if (grant_vld) begin in_burst = 1; span++; end
        else if (in_burst && burst_log.size() == 0) span = span;
      end
      check("t3_nbursts", int'(burst_log.size() >= 1), 1);
      if (burst_log.size() >= 1) check("t3_beats", burst_log[0], BL);
      check("t3_span_ge", int'(span >= 2 * BL - 1), 1);
    end

    // 4: grantee drops req after 10 beats, req[3] rises mid-burst
    do_reset(2);
    repeat (11) cyc(4'b0001, 1'b1);
    repeat (BL + 3) cyc(4'b1000, 1'b1);
    check("t4_ngrants", int'(grant_log.size() >= 2), 1);
    if (grant_log.size() >= 2) begin
      check("t4_grant0", grant_log[0], 0);
      check("t4_grant1", grant_log[1], 3);
    end
    if (burst_log.size() >= 1) check("t4_beats", burst_log[0], BL);

    // 5: overflow in idle is sticky and produces no write
    do_reset(2);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b1);
    repeat (3) cyc(4'b0000, 1'b0);
    check("t5_ovf_sticky", int'(ovf_err), 1);

    // 6: reset after 12 beats of a burst, then a clean burst for requester 1
    do_reset(2);
    repeat (13) cyc(4'b0100, 1'b1);
    check("t6_nbursts_pre", int'(burst_log.size()), 0);
    do_reset(2);
    repeat (BL + 4) cyc(4'b0010, 1'b1);
    if (grant_log.size() >= 1) check("t6_grant", grant_log[0], 1);
    if (burst_log.size() >= 1) check("t6_beats", burst_log[0], BL);
    check("t6_nbursts", int'(burst_log.size() >= 1), 1);

    // 7: randomized traffic
    do_reset(2);
    begin
      logic [N-1:0] r = '0;
      logic v;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 15) == 0) r = N'($urandom_range(0, (1 << N) - 1));
        if (m_phase == 1) v = ($urandom_range(0, 3) != 0);
        else              v = ($urandom_range(0, 63) == 0);
        cyc(r, v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
